uart_row_packet_rx: RTL

Parametrised packet engine between `uart_receiver` and `uart_transmiter` in the UART-to-VGA path. Parses framed row packets (Y address bytes, fixed-length pixel payload, optional XOR checksum, stop byte) from the received byte stream. Writes each payload byte into the frame buffer and queues one answer byte per received byte, plus a two-byte incomplete-packet report on inter-byte timeout, for the transmitter.

---
 rtl/uart_row_packet_rx.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_row_packet_rx.sv
// uart_row_packet_rx
// Parses framed row packets from the UART receive byte stream:
//   Y address bytes (big-endian), PAYLOAD pixel bytes, optional XOR
//   checksum byte, stop byte. Payload bytes are written to the frame
//   buffer. One answer byte per received byte is queued for the
//   transmitter, plus a two-byte incomplete-packet report when the gap
//   between bytes reaches TIMEOUT clock cycles.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_data    received byte, valid while rx_valid is high
//   rx_valid   one-cycle strobe from the receiver
//   ans_data   answer byte (first-word fall-through FIFO head)
//   ans_valid  answer available
//   ans_ready  transmitter accepts; transfer on ans_valid & ans_ready
//   wr_en      frame-buffer write strobe (registered)
//   wr_row     row address of the write
//   wr_col     column index of the write
//   wr_data    pixel byte of the write
//   row_done   one-cycle pulse, packet accepted
//   ans_ovf    sticky, an answer was dropped because the FIFO was full
//   dbg_state  current parser state (state_t encoding)
//
// Answer handshake: ans_data/ans_valid describe the FIFO head; a byte
// leaves the FIFO on every rising edge where ans_valid & ans_ready are
// both high, and ans_data does not change while ans_valid & !ans_ready.
module uart_row_packet_rx #(
    parameter int          Y_BYTES               = 2,
    parameter int          PAYLOAD               = 240,
    parameter int          CHK_EN                = 0,
    parameter int          TIMEOUT               = 100_000,
    parameter logic [7:0]  END_WORD              = 8'hDD,
    parameter logic [7:0]  ANSWER_CODE_TAKE_ROW  = 8'hCC,
    parameter logic [7:0]  ANSWER_CODE           = 8'hAA,
    parameter logic [7:0]  SUCCESSFULLY_RECEIVED = 8'hFF,
    parameter logic [7:0]  NOT_ALL_RECEIVED      = 8'h11,
    parameter logic [7:0]  ERROR_CODE            = 8'hEE,
    localparam int         ROW_W                 = 8 * Y_BYTES,
    localparam int         COL_W                 = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       ans_data,
    output logic             ans_valid,
    input  logic             ans_ready,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic             row_done,
    output logic             ans_ovf,
    output logic [2:0]       dbg_state
);

    localparam int TOTAL = Y_BYTES + PAYLOAD + CHK_EN + 1;
    localparam int RCV_W = $clog2(TOTAL + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // S_RPT is the second cycle of the timeout report (count byte); a byte
    // arriving in that single cycle is not parsed.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_CHK  = 3'd3,
        S_STOP = 3'd4,
        S_RPT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [RCV_W-1:0] rcv_q, rcv_d;
    logic [7:0]       chk_q, chk_d;
    logic             chk_ok_q, chk_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q, push_data_d;
    logic             wr_en_q, wr_en_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             row_done_q, row_done_d;

    logic             active;
    logic             timeout;
    logic [15:0]      remaining;
    logic [7:0]       rpt_byte;

    assign active    = (state_q == S_HDR) || (state_q == S_PAY) ||
                       (state_q == S_CHK) || (state_q == S_STOP);
    // Fires one cycle before the counter would read TIMEOUT so the first
    // report byte is pushed on the cycle the count is reached.
    assign timeout   = active && !rx_valid && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign remaining = 16'(TOTAL) - 16'(rcv_q);
    assign rpt_byte  = (remaining > 16'd255) ? 8'hFF : remaining[7:0];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rcv_d       = rcv_q;
        chk_d       = chk_q;
        chk_ok_d    = chk_ok_q;
        tmo_d       = (active && !rx_valid) ? tmo_q + 1'b1 : '0;
        push_d      = 1'b0;
        push_data_d = '0;
        wr_en_d     = 1'b0;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_data_d   = wr_data_q;
        row_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    row_d       = ROW_W'(rx_data);
                    chk_d       = '0;
                    chk_ok_d    = 1'b0;
                    col_d       = '0;
                    rcv_d       = RCV_W'(1);
                    push_d      = 1'b1;
                    push_data_d = ANSWER_CODE_TAKE_ROW;
                    state_d     = (Y_BYTES == 1) ? S_PAY : S_HDR;
                end
            end
            S_HDR: begin
                if (rx_valid) begin
                    row_d       = (row_q << 8) | ROW_W'(rx_data);
                    rcv_d       = rcv_q + 1'b1;
                    push_d      = 1'b1;
                    push_data_d = ANSWER_CODE_TAKE_ROW;
                    if (rcv_q == RCV_W'(Y_BYTES - 1)) begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (rx_valid) begin
                    wr_en_d     = 1'b1;
                    wr_row_d    = row_q;
                    wr_col_d    = col_q;
                    wr_data_d   = rx_data;
                    chk_d       = chk_q ^ rx_data;
                    rcv_d       = rcv_q + 1'b1;
                    push_d      = 1'b1;
                    push_data_d = ANSWER_CODE;
                    if (col_q == COL_W'(PAYLOAD - 1)) begin
                        state_d = (CHK_EN != 0) ? S_CHK : S_STOP;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    rcv_d       = rcv_q + 1'b1;
                    chk_ok_d    = (rx_data == chk_q);
                    push_d      = 1'b1;
                    push_data_d = (rx_data == chk_q) ? ANSWER_CODE : ERROR_CODE;
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_valid) begin
                    push_d  = 1'b1;
                    state_d = S_IDLE;
                    if ((rx_data == END_WORD) && (chk_ok_q || (CHK_EN == 0))) begin
                        push_data_d = SUCCESSFULLY_RECEIVED;
                        row_done_d  = 1'b1;
                    end else begin
                        push_data_d = ERROR_CODE;
                    end
                end
            end
            S_RPT: begin
                push_d      = 1'b1;
                push_data_d = rpt_byte;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Only reachable without rx_valid, so it never competes with a byte.
        if (timeout) begin
            push_d      = 1'b1;
            push_data_d = NOT_ALL_RECEIVED;
            state_d     = S_RPT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rcv_q       <= '0;
            chk_q       <= '0;
            chk_ok_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_en_q     <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rcv_q       <= rcv_d;
            chk_q       <= chk_d;
            chk_ok_q    <= chk_ok_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_en_q     <= wr_en_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            wr_data_q   <= wr_data_d;
            row_done_q  <= row_done_d;
        end
    end

    // Answer FIFO: 4 x 8, first-word fall-through. A push into a full FIFO
    // still lands when a pop happens on the same edge.
    logic [7:0] mem_q [4];
    logic [1:0] wp_q, rp_q;
    logic [2:0] cnt_q;
    logic       ovf_q;
    logic       pop;
    logic       full;
    logic       do_push;

    assign pop     = (cnt_q != 3'd0) && ans_ready;
    assign full    = (cnt_q == 3'd4);
    assign do_push = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= push_data_q;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_q && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ans_data  = mem_q[rp_q];
    assign ans_valid = (cnt_q != 3'd0);
    assign ans_ovf   = ovf_q;
    assign wr_en     = wr_en_q;
    assign wr_row    = wr_row_q;
    assign wr_col    = wr_col_q;
    assign wr_data   = wr_data_q;
    assign row_done  = row_done_q;
    assign dbg_state = state_q;

endmodule
